// File: rtl/counter_pkg.sv
// Shared definitions for the counter controller: state encoding, parameter
// defaults and a small next-state helper for the run/pause button.
package counter_pkg;

    localparam int unsigned CMAX_DEF      = 100;
    localparam int unsigned W_DEF         = 7;
    localparam int unsigned DB_CYCLES_DEF = 500000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // State reached by a start press; DONE is sticky until a load
    function automatic logic [1:0] start_next(input logic [1:0] s);
        case (s)
            ST_IDLE:  return ST_RUN;
            ST_RUN:   return ST_PAUSE;
            ST_PAUSE: return ST_RUN;
            default:  return s;
        endcase
    endfunction

endpackage

// File: rtl/counter_ctrl_if.sv
// Controller <-> counter bus: step/load strobes, load value, direction and
// the counter value fed back to the controller.
interface counter_ctrl_if
    import counter_pkg::*;
#(
    parameter int unsigned W = W_DEF
);
    logic         cnt_en;
    logic         load;
    logic [W-1:0] data_out;
    logic         updown;
    logic [W-1:0] count_in;

    modport master (output cnt_en, output load, output data_out, output updown,
                    input  count_in);
    modport slave  (input  cnt_en, input  load, input  data_out, input  updown,
                    output count_in);
endinterface

// File: rtl/btn_debounce.sv
// Button front end: 2-flop synchronizer, optional stability filter
// (enabled by defining DEBOUNCE_EN) and a registered rising-edge pulse.
// A button already held when reset releases stays silent until it has been
// seen released once.
module btn_debounce
    import counter_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
)(
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    if (DB_CYCLES < 1) begin : g_bad_db
        $error("btn_debounce: DB_CYCLES must be at least 1");
    end

    logic       sync_q1;
    logic       sync_q2;
    logic [1:0] primed;
    logic       armed;
    logic       level;
    logic       level_q;

    // Two-flop synchronizer for the raw button
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
        end
    end

    // Arm only after a genuine released sample has passed the synchronizer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            primed <= 2'b00;
            armed  <= 1'b0;
        end else begin
            primed <= {primed[0], 1'b1};
            if (primed[1] && !sync_q2) begin
                armed <= 1'b1;
            end
        end
    end

`ifdef DEBOUNCE_EN
    localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic [CW-1:0] db_cnt;
    logic          stable;

    // Accept a new level after DB_CYCLES consecutive differing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt <= '0;
            stable <= 1'b0;
        end else if (sync_q2 == stable) begin
            db_cnt <= '0;
        end else if (db_cnt == CW'(DB_CYCLES - 1)) begin
            db_cnt <= '0;
            stable <= sync_q2;
        end else begin
            db_cnt <= db_cnt + CW'(1);
        end
    end

    assign level = stable;
`else
    assign level = sync_q2;
`endif

    // One-cycle pulse on each accepted rising edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
            rise    <= 1'b0;
        end else begin
            level_q <= level;
            rise    <= level & ~level_q & armed;
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// Run/pause/load controller for an external up/down counter.
// Optional button debounce is enabled by defining DEBOUNCE_EN.
module counter_ctrl
    import counter_pkg::*;
#(
    parameter int unsigned CMAX      = CMAX_DEF,
    parameter int unsigned W         = W_DEF,
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         start_btn,
    input  logic         load_btn,
    input  logic [W-1:0] sw_data,
    input  logic         sw_updown,
    input  logic         sw_oneshot,
    counter_ctrl_if.master bus,
    output logic [1:0]   state_o
);

    if ((64'd1 << W) < 64'(CMAX)) begin : g_bad_w
        $error("counter_ctrl: W too small for CMAX");
    end

    localparam logic [W-1:0] TOP = W'(CMAX - 1);

    logic         start_p;
    logic         load_p;
    logic [1:0]   state;
    logic [1:0]   state_d;
    logic         cnt_en_d;
    logic         load_d;
    logic [W-1:0] data_d;
    logic         updown_d;
    logic         at_term_c;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_start_db (
        .clk  (clk),
        .rst  (rst),
        .btn  (start_btn),
        .rise (start_p)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_load_db (
        .clk  (clk),
        .rst  (rst),
        .btn  (load_btn),
        .rise (load_p)
    );

    // Next state and next output values; load has priority over start
    always_comb begin
        state_d   = state;
        cnt_en_d  = 1'b0;
        load_d    = 1'b0;
        data_d    = bus.data_out;
        updown_d  = (state == ST_RUN) ? bus.updown : sw_updown;
        at_term_c = sw_oneshot &&
                    (bus.updown ? (bus.count_in == TOP) : (bus.count_in == '0));

        if (load_p) begin
            load_d  = 1'b1;
            data_d  = (sw_data > TOP) ? TOP : sw_data;
            state_d = ST_IDLE;
        end else if (start_p) begin
            state_d = start_next(state);
        end else if (state == ST_RUN && tick) begin
            if (at_term_c) begin
                state_d = ST_DONE;
            end else begin
                cnt_en_d = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Registered counter-bus outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.cnt_en   <= 1'b0;
            bus.load     <= 1'b0;
            bus.data_out <= '0;
            bus.updown   <= 1'b1;
        end else begin
            bus.cnt_en   <= cnt_en_d;
            bus.load     <= load_d;
            bus.data_out <= data_d;
            bus.updown   <= updown_d;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl with a cycle-level reference model.
module tb_counter_ctrl;
    import counter_pkg::*;

    localparam int unsigned CMAX = 100;
    localparam int unsigned W    = 7;
    localparam int unsigned DB   = 4;
`ifdef DEBOUNCE_EN
    localparam int DBN = DB;
    localparam int LAT = 4;
`else
    localparam int DBN = 1;
    localparam int LAT = 3;
`endif
    localparam int HN = 4096;

    logic         clk = 1'b0;
    logic         rst;
    logic         tick;
    logic         start_btn;
    logic         load_btn;
    logic [W-1:0] sw_data;
    logic         sw_updown;
    logic         sw_oneshot;
    logic [1:0]   state_o;

    counter_ctrl_if #(.W(W)) bus ();

    counter_ctrl #(.CMAX(CMAX), .W(W), .DB_CYCLES(DB)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .start_btn  (start_btn),
        .load_btn   (load_btn),
        .sw_data    (sw_data),
        .sw_updown  (sw_updown),
        .sw_oneshot (sw_oneshot),
        .bus        (bus),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: button sample history, accepted levels, press events
    int   cyc;
    bit   raw_s [HN];
    bit   raw_l [HN];
    bit   ev_s  [HN];
    bit   ev_l  [HN];
    bit   acc_s, acc_l, arm_s, arm_l;
    logic [1:0] m_state;
    logic       m_cnt_en, m_load, m_updown;
    int         m_data;
    int         tick_per;

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // True when the last DBN post-reset samples of a button all equal v
    function automatic bit run_of(input int k, input bit which, input bit v);
        for (int i = 0; i < DBN; i++) begin
            if (k - i < 1) return 1'b0;
            if ((which ? raw_l[k-i] : raw_s[k-i]) != v) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        cyc = 0;
        for (int i = 0; i < HN; i++) begin
            raw_s[i] = 1'b0; raw_l[i] = 1'b0; ev_s[i] = 1'b0; ev_l[i] = 1'b0;
        end
        acc_s = 1'b0; acc_l = 1'b0; arm_s = 1'b0; arm_l = 1'b0;
        m_state = ST_IDLE; m_cnt_en = 1'b0; m_load = 1'b0; m_updown = 1'b1; m_data = 0;
    endtask

    // Advance the model by one clock edge using the inputs present at the edge
    task automatic model_edge();
        logic [1:0] s;
        logic       up_new;
        cyc++;
        if (cyc + LAT + 1 >= HN) begin
            $display("FAIL history_overflow cyc=%0d limit=%0d", cyc, HN);
            $fatal(1);
        end
        raw_s[cyc] = start_btn;
        raw_l[cyc] = load_btn;
        if (acc_s != start_btn && run_of(cyc, 1'b0, start_btn)) begin
            acc_s = start_btn;
            if (acc_s && arm_s) ev_s[cyc+LAT] = 1'b1;
        end
        if (!start_btn) arm_s = 1'b1;
        if (acc_l != load_btn && run_of(cyc, 1'b1, load_btn)) begin
            acc_l = load_btn;
            if (acc_l && arm_l) ev_l[cyc+LAT] = 1'b1;
        end
        if (!load_btn) arm_l = 1'b1;

        s        = m_state;
        up_new   = (s != ST_RUN) ? sw_updown : m_updown;
        m_cnt_en = 1'b0;
        m_load   = 1'b0;
        if (ev_l[cyc]) begin
            m_load  = 1'b1;
            m_data  = (int'(sw_data) > int'(CMAX) - 1) ? int'(CMAX) - 1 : int'(sw_data);
            m_state = ST_IDLE;
        end else if (ev_s[cyc] && s != ST_DONE) begin
            m_state = (s == ST_RUN) ? ST_PAUSE : ST_RUN;
        end else if (s == ST_RUN && tick) begin
            if (sw_oneshot && int'(bus.count_in) == (m_updown ? int'(CMAX) - 1 : 0))
                m_state = ST_DONE;
            else
                m_cnt_en = 1'b1;
        end
        m_updown = up_new;
    endtask

    task automatic check_all();
        cmp("cnt_en",   32'(bus.cnt_en),   32'(m_cnt_en));
        cmp("load",     32'(bus.load),     32'(m_load));
        cmp("data_out", 32'(bus.data_out), 32'(m_data));
        cmp("updown",   32'(bus.updown),   32'(m_updown));
        cmp("state",    32'(state_o),      32'(m_state));
    endtask

    task automatic step();
        if (tick_per > 0)       tick = ((cyc % tick_per) == tick_per - 1);
        else if (tick_per < 0)  tick = ($urandom_range(0, 5) == 0);
        else                    tick = 1'b0;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press(input bit s, input bit l, input int len);
        if (s) start_btn = 1'b1;
        if (l) load_btn  = 1'b1;
        steps(len);
        start_btn = 1'b0;
        load_btn  = 1'b0;
        steps(12);
    endtask

    // Assert reset between edges and check outputs respond without a clock
    task automatic do_reset(input bit hold_start);
        #2;
        rst       = 1'b1;
        start_btn = hold_start;
        #1;
        cmp("rst_cnt_en",   32'(bus.cnt_en),   32'(0));
        cmp("rst_load",     32'(bus.load),     32'(0));
        cmp("rst_data_out", 32'(bus.data_out), 32'(0));
        cmp("rst_updown",   32'(bus.updown),   32'(1));
        cmp("rst_state",    32'(state_o),      32'(ST_IDLE));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b0; tick = 1'b0; start_btn = 1'b0; load_btn = 1'b0;
        sw_data = '0; sw_updown = 1'b1; sw_oneshot = 1'b0; bus.count_in = 7'd50;
        tick_per = 0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset(1'b0);
        steps(8);

        // Start, then count with a tick every 10 cycles
        press(1'b1, 1'b0, 8);
        tick_per = 10;
        steps(60);

        // Direction frozen in RUN, followed again in PAUSE
        sw_updown = 1'b0;
        steps(20);
        press(1'b1, 1'b0, 8);
        steps(10);
        sw_updown = 1'b1;
        steps(5);

        // Load with clamp, then an in-range value
        sw_data = 7'd120;
        press(1'b0, 1'b1, 8);
        sw_data = 7'd42;
        press(1'b0, 1'b1, 8);

        // One-shot up: terminal tick stops in DONE; start ignored; load exits
        sw_oneshot = 1'b1;
        bus.count_in = 7'd50;
        press(1'b1, 1'b0, 8);
        tick_per = 5;
        steps(20);
        bus.count_in = 7'd99;
        steps(12);
        press(1'b1, 1'b0, 8);
        press(1'b0, 1'b1, 8);

        // One-shot down: terminal at zero
        sw_updown = 1'b0;
        steps(3);
        bus.count_in = 7'd0;
        press(1'b1, 1'b0, 8);
        steps(12);
        press(1'b0, 1'b1, 8);
        sw_updown = 1'b1;
        sw_oneshot = 1'b0;
        bus.count_in = 7'd99;

        // Start and load together in RUN: load wins
        press(1'b1, 1'b0, 8);
        steps(10);
        press(1'b1, 1'b1, 8);

        // Short glitch then a longer press on start
        tick_per = 0;
        start_btn = 1'b1; steps(3); start_btn = 1'b0; steps(12);
        start_btn = 1'b1; steps(6); start_btn = 1'b0; steps(12);

        // Reset mid-RUN aborts immediately
        tick_per = 3;
        steps(15);
        do_reset(1'b0);
        steps(10);

        // Start held through reset release gives no pulse until re-pressed
        press(1'b1, 1'b0, 8);
        do_reset(1'b1);
        steps(15);
        start_btn = 1'b0;
        steps(12);
        press(1'b1, 1'b0, 8);

        // Randomized operation
        begin
            int hold_s = 0;
            int hold_l = 0;
            tick_per = -1;
            for (int i = 0; i < 1500; i++) begin
                int r;
                if ($urandom_range(0, 19) == 0) sw_updown  = ~sw_updown;
                if ($urandom_range(0, 39) == 0) sw_oneshot = ~sw_oneshot;
                if ($urandom_range(0, 9)  == 0) sw_data    = W'($urandom_range(0, 127));
                r = int'($urandom_range(0, 3));
                bus.count_in = (r == 0) ? 7'd0 : (r == 1) ? 7'd99 : W'($urandom_range(0, 127));
                if (hold_s == 0 && $urandom_range(0, 24) == 0) hold_s = int'($urandom_range(1, 9));
                if (hold_l == 0 && $urandom_range(0, 59) == 0) hold_l = int'($urandom_range(1, 9));
                start_btn = (hold_s > 0);
                load_btn  = (hold_l > 0);
                if (hold_s > 0) hold_s--;
                if (hold_l > 0) hold_l--;
                step();
            end
            start_btn = 1'b0;
            load_btn  = 1'b0;
            tick_per  = 0;
            steps(10);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter CMAX, default 100, number of counter states (count range 0..CMAX-1).
REQ-002 Parameter W, default 7, data width; SHALL satisfy 2**W >= CMAX.
REQ-003 Parameter DB_CYCLES, default 500000, debounce stability window in clk cycles (10 ms at 50 MHz).
REQ-004 clk  input  1  system clock (50 MHz board clock).
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 tick  input  1  one-cycle enable strobe from the clock divider (5 Hz rate).
REQ-007 start_btn  input  1  raw run/pause button, active-high.
REQ-008 load_btn  input  1  raw load button, active-high.
REQ-009 sw_data  input  W  preset value for load.
REQ-010 sw_updown  input  1  requested direction, 1 = up, 0 = down.
REQ-011 sw_oneshot  input  1  1 = stop at terminal count, 0 = free-run with wrap.
REQ-012 count_in  input  W  current counter value, fed back from the counter.
REQ-013 cnt_en  output  1  one-cycle count-step strobe to the counter.
REQ-014 load  output  1  one-cycle load strobe to the counter.
REQ-015 data_out  output  W  load value presented with load.
REQ-016 updown  output  1  direction to the counter.
REQ-017 state_o  output  2  current FSM state, for display and debug.

Function
REQ-018 FSM states: IDLE=0, RUN=1, PAUSE=2, DONE=3.
REQ-019 Button inputs pass through a 2-flop synchronizer; a rising-edge detector produces one-cycle start_p and load_p pulses.
REQ-020 load_p in any state: load=1 for exactly one cycle, data_out = min(sw_data, CMAX-1), next state IDLE.
REQ-021 load_p and start_p in the same cycle: load wins and start_p is discarded.
REQ-022 start_p transitions: IDLE->RUN, RUN->PAUSE, PAUSE->RUN; DONE ignores start_p.
REQ-023 RUN: cnt_en=1 in the cycle after tick is sampled high (latency 1); cnt_en=0 in all other states.
REQ-024 updown follows sw_updown in IDLE, PAUSE and DONE; it is frozen in RUN.
REQ-025 One-shot terminal: in RUN with sw_oneshot=1, a tick with count_in == CMAX-1 (up) or 0 (down) produces no cnt_en, and the next state is DONE.
REQ-026 With sw_oneshot=0 the controller never blocks cnt_en; wrap-around is the counter's job.
REQ-027 A tick coinciding with start_p RUN->PAUSE produces no cnt_en.
REQ-028 A tick coinciding with a load cycle produces no cnt_en.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 rst=1 asynchronously forces: state IDLE, cnt_en=0, load=0, data_out=0, updown=1, and all synchronizer, edge and debounce registers to 0.
REQ-031 Reset asserted mid-RUN aborts immediately; no strobe is emitted in the cycle after release.
REQ-032 A button held through reset release SHALL NOT generate a pulse until it is released and pressed again.

Configuration
REQ-033 DEBOUNCE_EN defined: each synchronized button is accepted only after DB_CYCLES consecutive stable samples before edge detection.
REQ-034 DEBOUNCE_EN undefined: synchronizer and edge detector only; DB_CYCLES unused.

Structure
REQ-035 Shared package counter_pkg holds the state encoding and the default values of CMAX, W and DB_CYCLES.
REQ-036 A debounce sub-module, btn_debounce (sync, optional filter, rise pulse), is instantiated once per button.

Verification (DB_CYCLES=4 in simulation)
REQ-037 Reset, then start pulse, tick every 10 cycles -> state RUN; cnt_en high exactly 1 cycle after each tick; no cnt_en in other cycles.
REQ-038 sw_data=120, load press -> one-cycle load with data_out=99, state IDLE; sw_data=42 -> data_out=42.
REQ-039 sw_oneshot=1, up, count_in=99 with tick -> no cnt_en, state DONE; start press ignored; load press -> IDLE.
REQ-040 RUN with sw_updown toggled 1->0 -> updown stays 1; press start to enter PAUSE -> updown becomes 0.
REQ-041 Start and load pressed in the same cycle during RUN -> load pulse, state IDLE, no PAUSE.
REQ-042 DEBOUNCE_EN: 3-cycle glitch on start_btn -> no state change; 6-cycle press -> exactly one transition. Assert rst mid-RUN -> all outputs at reset values immediately.
